px_scan_decoder: RTL

- Receive end of the multiplexed 8-digit seven-segment scan bus.
- Samples the active-low anode vector and the active-low cathode vector, and rebuilds the 8 displayed digit patterns into a double-buffered register bank.
- Checks scan order and flags protocol errors.
- Used as an on-board loopback monitor and as the bench-side checker for the display path.

---
 rtl/px_pkg.sv | 33 +++
 rtl/px_scan_decoder_sync2.sv | 24 ++
 rtl/px_scan_decoder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/px_pkg.sv
// Shared types and helpers for the seven-segment scan-bus decoder.
package px_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int DIGIT_W = 3;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic {HUNT, TRACK} state_t;

   typedef struct packed {
      logic valid;
      logic multi;
      logic [DIGIT_W-1:0] idx;
   } sel_t;

   // Classify an active-low anode vector: exactly one zero is a valid select.
   function automatic sel_t onehot0_index(input logic [NUM_DIGITS-1:0] an);
      sel_t r;
      int zeros;
      r = '0;
      zeros = 0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (!an[k]) begin
            zeros++;
            r.idx = DIGIT_W'(k);
         end
      end
      r.valid = (zeros == 1);
      r.multi = (zeros > 1);
      return r;
   endfunction

endpackage

// File: rtl/px_scan_decoder_sync2.sv
// Two-flop synchronizer with a configurable reset value.
module px_sync2 #(
   parameter int WIDTH = 16,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] s1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= RST_VAL;
         q  <= RST_VAL;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/px_scan_decoder.sv
// Rebuilds the 8 digit patterns from a multiplexed seven-segment scan bus
// into a double-buffered bank and flags scan-protocol errors.
module px_scan_decoder
   import px_pkg::*;
#(
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 1048576
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   a_in,
   input  logic [7:0]   seg_in,
   input  logic         clr_err,
   input  logic [2:0]   rd_sel,
   output logic [7:0]   rd_seg,
   output logic [2:0]   cur_digit,
   output logic         frame_done,
   output logic         seq_err,
   output logic         sel_err,
   output logic         stall
);

   localparam logic [7:0]  SET_LAST = 8'(SETTLE - 1);
   localparam logic [23:0] T_LAST   = 24'(TIMEOUT - 1);

   logic [15:0] s2;
   logic [15:0] cmp;
   logic [7:0]  cnt;
   logic [7:0]  cnt_nx;
   logic        strobe;
   sel_t        sel;
   state_t      state;
   logic [2:0]  expd;
   logic [2:0]  prev;
   logic [7:0]  seg;
   logic [23:0] tcnt;
   logic        cap;
   logic        seq_set;
   logic        sel_set;
   logic [7:0]  shadow [NUM_DIGITS];
   logic [7:0]  bank   [NUM_DIGITS];

   px_sync2 #(.WIDTH(16), .RST_VAL(16'hFFFF)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     ({a_in, seg_in}),
      .q     (s2)
   );

   assign seg    = s2[7:0];
   assign sel    = onehot0_index(s2[15:8]);
   assign prev   = expd - 3'd1;
   assign rd_seg = bank[rd_sel];

   always_comb begin
      if (s2 != cmp)
         cnt_nx = '0;
      else if (cnt == 8'hFF)
         cnt_nx = cnt;
      else
         cnt_nx = cnt + 8'd1;
   end

   assign strobe = (cnt_nx == SET_LAST);

   always_comb begin
      cap     = 1'b0;
      seq_set = 1'b0;
      sel_set = strobe && sel.multi;
      if (strobe && sel.valid) begin
         unique case (state)
            HUNT: cap = (sel.idx == 3'd0);
            TRACK: begin
               seq_set = (sel.idx != expd) && (sel.idx != prev);
               cap = !seq_set || (sel.idx == 3'd0);
            end
            default: cap = 1'b0;
         endcase
      end
   end

   // cmp resets to the complement of the sync value so a pair stable
   // from reset still counts as one fresh dwell.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmp  <= '0;
         cnt  <= '0;
         tcnt <= '0;
      end else begin
         cmp <= s2;
         cnt <= cnt_nx;
         if (cap)
            tcnt <= '0;
         else if (tcnt != T_LAST)
            tcnt <= tcnt + 24'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seq_err <= 1'b0;
         sel_err <= 1'b0;
         stall   <= 1'b0;
      end else begin
         seq_err <= seq_set | (seq_err & ~clr_err);
         sel_err <= sel_set | (sel_err & ~clr_err);
         stall   <= ((tcnt == T_LAST) && !cap) | (stall & ~clr_err);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= HUNT;
         expd       <= '0;
         cur_digit  <= '0;
         frame_done <= 1'b0;
         for (int j = 0; j < NUM_DIGITS; j++) begin
            shadow[j] <= SEG_BLANK;
            bank[j]   <= SEG_BLANK;
         end
      end else begin
         frame_done <= 1'b0;
         if (strobe && sel.valid) begin
            unique case (state)
               HUNT: begin
                  if (sel.idx == 3'd0) begin
                     shadow[0] <= seg;
                     cur_digit <= '0;
                     expd      <= 3'd1;
                     state     <= TRACK;
                  end
               end
               TRACK: begin
                  if (sel.idx == expd) begin
                     shadow[sel.idx] <= seg;
                     cur_digit       <= sel.idx;
                     expd            <= sel.idx + 3'd1;
                     if (sel.idx == 3'd7) begin
                        for (int j = 0; j < NUM_DIGITS - 1; j++)
                           bank[j] <= shadow[j];
                        bank[7]    <= seg;
                        frame_done <= 1'b1;
                     end
                  end else if (sel.idx == prev) begin
                     shadow[sel.idx] <= seg;
                  end else if (sel.idx == 3'd0) begin
                     shadow[0] <= seg;
                     cur_digit <= '0;
                     expd      <= 3'd1;
                  end else begin
                     state <= HUNT;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule
